fir_accumulator: RTL

Accumulator and sample-output stage for the FIR processor core, directly downstream of the execute-stage ALU. It registers each VMAC result from the ALU and feeds it back as the ALU's `accumData` operand. It counts taps per output sample and, on the final tap, emits a formatted Q15 sample through a valid/ready handshake toward the SoC interconnect. The ALU itself is combinational; this block holds all of the multiply-accumulate state.

---
 rtl/fir_core_pkg.sv | 29 ++
 rtl/fir_accumulator_if.sv | 30 +++
 rtl/q15_saturate.sv | 28 ++
 rtl/fir_accumulator.sv | 111 +++++++++++
 4 files changed

// File: rtl/fir_core_pkg.sv
// Shared FIR core definitions: accumulator FSM states, ALU opcodes, Q15 limits.
package fir_core_pkg;

  localparam int unsigned Q15_W = 16;

  typedef enum logic [0:0] {
    ACC_IDLE  = 1'b0,
    ACC_ACCUM = 1'b1
  } acc_state_e;

  // Opcode encodings shared with the decoder so both sides agree on VMAC
  typedef enum logic [2:0] {
    ALU_NOP  = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_MUL  = 3'd3,
    VMAC     = 3'd4,
    ALU_PASS = 3'd5
  } alu_op_e;

  localparam logic signed [Q15_W-1:0] Q15_MAX = 16'sh7FFF;
  localparam logic signed [Q15_W-1:0] Q15_MIN = 16'sh8000;

  // Tap counter width; a single-tap configuration still needs one bit
  function automatic int unsigned cnt_width(input int unsigned taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/fir_accumulator_if.sv
// MAC-beat and sample-output bus between the ALU/interconnect side and the accumulator.
interface fir_accumulator_if #(
  parameter int unsigned TAPS   = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OUT_W  = 16
);
  localparam int unsigned CNT_W = fir_core_pkg::cnt_width(TAPS);

  logic              macValid;
  logic              macReady;
  logic [DATA_W-1:0] macResult;
  logic              macClear;
  logic [DATA_W-1:0] accumData;
  logic [CNT_W-1:0]  tapCount;
  logic [OUT_W-1:0]  sampleOut;
  logic              sampleValid;
  logic              sampleReady;
  logic              saturated;

  modport master (
    output macValid, macResult, macClear, sampleReady,
    input  macReady, accumData, tapCount, sampleOut, sampleValid, saturated
  );

  modport slave (
    input  macValid, macResult, macClear, sampleReady,
    output macReady, accumData, tapCount, sampleOut, sampleValid, saturated
  );

endinterface

// File: rtl/q15_saturate.sv
// Combinational signed clamp from DATA_W down to OUT_W with an overflow flag.
module q15_saturate #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OUT_W  = 16
) (
  input  logic [DATA_W-1:0] din,
  output logic [OUT_W-1:0]  dout,
  output logic              ovf
);

  localparam int unsigned      HI_W    = DATA_W - OUT_W + 1;
  localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic [HI_W-1:0] hi;

  assign hi = din[DATA_W-1:OUT_W-1];

  // Value fits only when every bit above the output sign bit matches it
  always_comb begin
    ovf  = (hi != {HI_W{1'b0}}) && (hi != {HI_W{1'b1}});
    dout = din[OUT_W-1:0];
    if (ovf) begin
      dout = din[DATA_W-1] ? NEG_MIN : POS_MAX;
    end
  end

endmodule

// File: rtl/fir_accumulator.sv
// FIR accumulator: holds the VMAC running sum, counts taps, emits a Q15 sample.
// Define FIR_ACC_SATURATE_EN to clamp samples instead of wrapping them.
module fir_accumulator
  import fir_core_pkg::*;
#(
  parameter int unsigned TAPS   = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OUT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  fir_accumulator_if.slave    bus
);

  localparam int unsigned      CNT_W    = cnt_width(TAPS);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

  acc_state_e        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              valid_q, valid_d;
  logic              sat_q, sat_d;

  logic [OUT_W-1:0]  fmt_data;
  logic              fmt_sat;
  logic              final_beat;
  logic              out_stall;
  logic              mac_ready;
  logic              accept;

`ifdef FIR_ACC_SATURATE_EN
  q15_saturate #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_sat (
    .din  (bus.macResult),
    .dout (fmt_data),
    .ovf  (fmt_sat)
  );
`else
  logic unused_high;
  assign fmt_data    = bus.macResult[OUT_W-1:0];
  assign fmt_sat     = 1'b0;
  assign unused_high = ^bus.macResult[DATA_W-1:OUT_W];
`endif

  // Only a final beat can be stalled, and only by an unconsumed sample
  assign final_beat = (cnt_q == LAST_TAP);
  assign out_stall  = valid_q && !bus.sampleReady;
  assign mac_ready  = !bus.macClear && !(final_beat && out_stall);
  assign accept     = bus.macValid && mac_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = valid_q;
    sat_d   = sat_q;

    if (valid_q && bus.sampleReady) begin
      valid_d = 1'b0;
    end

    if (bus.macClear) begin
      state_d = ACC_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (accept) begin
      if (final_beat) begin
        state_d = ACC_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        out_d   = fmt_data;
        valid_d = 1'b1;
        sat_d   = fmt_sat;
      end else begin
        state_d = ACC_ACCUM;
        acc_d   = bus.macResult;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.macReady    = mac_ready;
  assign bus.accumData   = acc_q;
  assign bus.tapCount    = cnt_q;
  assign bus.sampleOut   = out_q;
  assign bus.sampleValid = valid_q;
  assign bus.saturated   = sat_q;

endmodule
